// File: rtl/core_alu_md_pkg.sv
// Shared definitions for the ALU / multiply-divide block: function codes,
// FSM state encoding and operation-class helpers.
package core_alu_md_pkg;

    localparam int ALU_FUNC_W = 5;
    typedef logic [ALU_FUNC_W-1:0] alu_func_t;

    localparam alu_func_t FN_ADD    = 5'd0;
    localparam alu_func_t FN_SUB    = 5'd1;
    localparam alu_func_t FN_XOR    = 5'd2;
    localparam alu_func_t FN_OR     = 5'd3;
    localparam alu_func_t FN_AND    = 5'd4;
    localparam alu_func_t FN_SLL    = 5'd5;
    localparam alu_func_t FN_SRL    = 5'd6;
    localparam alu_func_t FN_SRA    = 5'd7;
    localparam alu_func_t FN_SLT    = 5'd8;
    localparam alu_func_t FN_SLTU   = 5'd9;
    localparam alu_func_t FN_MUL    = 5'd10;
    localparam alu_func_t FN_MULH   = 5'd11;
    localparam alu_func_t FN_MULHSU = 5'd12;
    localparam alu_func_t FN_MULHU  = 5'd13;
    localparam alu_func_t FN_DIV    = 5'd14;
    localparam alu_func_t FN_DIVU   = 5'd15;
    localparam alu_func_t FN_REM    = 5'd16;
    localparam alu_func_t FN_REMU   = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } md_state_t;

    function automatic logic fn_is_mul(input alu_func_t f);
        return (f >= FN_MUL) && (f <= FN_MULHU);
    endfunction

    function automatic logic fn_is_div(input alu_func_t f);
        return (f >= FN_DIV) && (f <= FN_REMU);
    endfunction

    function automatic logic fn_div_signed(input alu_func_t f);
        return (f == FN_DIV) || (f == FN_REM);
    endfunction

    function automatic logic fn_a_signed(input alu_func_t f);
        return (f == FN_MULH) || (f == FN_MULHSU) || fn_div_signed(f);
    endfunction

    function automatic logic fn_b_signed(input alu_func_t f);
        return (f == FN_MULH) || fn_div_signed(f);
    endfunction

    // Upper product half for MULH*, remainder for REM*.
    function automatic logic fn_hi(input alu_func_t f);
        return (f == FN_MULH) || (f == FN_MULHSU) || (f == FN_MULHU) ||
               (f == FN_REM) || (f == FN_REMU);
    endfunction

endpackage

// File: rtl/core_alu_md_muldiv_iter.sv
// Radix-2 iterative multiply/divide engine: magnitudes loaded on start, one
// step per cycle for XLEN cycles, sign-corrected result valid with o_done.
module core_muldiv_iter
    import core_alu_md_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic            i_is_div,
    input  logic            i_hi,
    input  logic            i_a_signed,
    input  logic            i_b_signed,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_done,
    output logic [XLEN-1:0] o_res
);
    localparam int CW = $clog2(XLEN);

    logic              r_busy;
    logic [CW-1:0]     r_cnt;
    logic [2*XLEN-1:0] r_p;
    logic [XLEN-1:0]   r_b;
    logic              r_is_div, r_hi, r_neg_main, r_neg_rem;

    logic              w_a_neg, w_b_neg;
    logic [XLEN-1:0]   w_a_mag, w_b_mag, w_quot, w_rem;
    logic [XLEN:0]     w_sum, w_shift, w_diff;
    logic [2*XLEN-1:0] w_p_nxt, w_prod;

    assign w_a_neg = i_a_signed & i_a[XLEN-1];
    assign w_b_neg = i_b_signed & i_b[XLEN-1];
    assign w_a_mag = w_a_neg ? (~i_a + 1'b1) : i_a;
    assign w_b_mag = w_b_neg ? (~i_b + 1'b1) : i_b;

    // r_p holds {acc, low} for multiply and {remainder, quotient} for divide.
    always_comb begin
        w_sum   = {1'b0, r_p[2*XLEN-1:XLEN]} + (r_p[0] ? {1'b0, r_b} : '0);
        w_shift = {r_p[2*XLEN-1:XLEN], r_p[XLEN-1]};
        w_diff  = w_shift - {1'b0, r_b};
        if (r_is_div) begin
            w_p_nxt = w_diff[XLEN] ? {w_shift[XLEN-1:0], r_p[XLEN-2:0], 1'b0}
                                   : {w_diff[XLEN-1:0],  r_p[XLEN-2:0], 1'b1};
        end else begin
            w_p_nxt = {w_sum, r_p[XLEN-1:1]};
        end
    end

    assign w_prod = r_neg_main ? (~w_p_nxt + 1'b1) : w_p_nxt;
    assign w_quot = r_neg_main ? (~w_p_nxt[XLEN-1:0] + 1'b1) : w_p_nxt[XLEN-1:0];
    assign w_rem  = r_neg_rem ? (~w_p_nxt[2*XLEN-1:XLEN] + 1'b1) : w_p_nxt[2*XLEN-1:XLEN];
    assign o_res  = r_is_div ? (r_hi ? w_rem : w_quot)
                             : (r_hi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0]);
    assign o_done = r_busy && (r_cnt == CW'(XLEN-1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
        end else if (r_busy) begin
            r_cnt <= r_cnt + 1'b1;
            if (o_done) r_busy <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_start) begin
            r_p        <= {{XLEN{1'b0}}, w_a_mag};
            r_b        <= w_b_mag;
            r_is_div   <= i_is_div;
            r_hi       <= i_hi;
            r_neg_main <= w_a_neg ^ w_b_neg;
            r_neg_rem  <= w_a_neg;
        end else if (r_busy) begin
            r_p <= w_p_nxt;
        end
    end

endmodule

// File: rtl/core_alu_md.sv
// ALU with multiply/divide extension behind a valid/ready request/response
// handshake; basic ops finish in one CALC cycle, mul/div iterate XLEN cycles.
module core_alu_md
    import core_alu_md_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int FAST_MUL = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_in,
    output logic                  req_ready_out,
    input  logic [ALU_FUNC_W-1:0] func_in,
    input  logic [XLEN-1:0]       opnum1_in,
    input  logic [XLEN-1:0]       opnum2_in,
    output logic                  resp_valid_out,
    input  logic                  resp_ready_in,
    output logic [XLEN-1:0]       res_out,
    output logic                  busy_out
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    md_state_t              r_state, w_state_nxt;
    alu_func_t              r_func;
    logic [XLEN-1:0]        r_op1, r_op2, r_res;
    logic                   r_iter;
    logic                   w_accept, w_div_special, w_start, w_iter_done;
    logic                   w_div_zero, w_div_ovf;
    logic [XLEN-1:0]        w_iter_res, w_fast_res;
    logic [SHW-1:0]         w_shamt;
    logic signed [2*XLEN-1:0] w_ma, w_mb, w_mprod;

    assign w_accept      = req_valid_in && (r_state == ST_IDLE);
    assign w_div_special = fn_is_div(func_in) && ((opnum2_in == '0) ||
                           (fn_div_signed(func_in) && (opnum1_in == MOST_NEG) && (opnum2_in == '1)));
    assign w_start       = w_accept && ((fn_is_div(func_in) && !w_div_special) ||
                                        (fn_is_mul(func_in) && (FAST_MUL == 0)));

    core_muldiv_iter #(.XLEN(XLEN)) u_iter (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_start),
        .i_is_div   (fn_is_div(func_in)),
        .i_hi       (fn_hi(func_in)),
        .i_a_signed (fn_a_signed(func_in)),
        .i_b_signed (fn_b_signed(func_in)),
        .i_a        (opnum1_in),
        .i_b        (opnum2_in),
        .o_done     (w_iter_done),
        .o_res      (w_iter_res)
    );

    assign w_shamt    = r_op2[SHW-1:0];
    assign w_div_zero = (r_op2 == '0);
    assign w_div_ovf  = fn_div_signed(r_func) && (r_op1 == MOST_NEG) && (r_op2 == '1);
    assign w_ma       = {{XLEN{fn_a_signed(r_func) & r_op1[XLEN-1]}}, r_op1};
    assign w_mb       = {{XLEN{fn_b_signed(r_func) & r_op2[XLEN-1]}}, r_op2};
    assign w_mprod    = w_ma * w_mb;

    // Single-cycle results; div entries only cover the zero/overflow shortcuts.
    always_comb begin
        w_fast_res = '0;
        case (r_func)
            FN_ADD:    w_fast_res = r_op1 + r_op2;
            FN_SUB:    w_fast_res = r_op1 - r_op2;
            FN_XOR:    w_fast_res = r_op1 ^ r_op2;
            FN_OR:     w_fast_res = r_op1 | r_op2;
            FN_AND:    w_fast_res = r_op1 & r_op2;
            FN_SLL:    w_fast_res = r_op1 << w_shamt;
            FN_SRL:    w_fast_res = r_op1 >> w_shamt;
            FN_SRA:    w_fast_res = XLEN'($signed(r_op1) >>> w_shamt);
            FN_SLT:    w_fast_res = {{(XLEN-1){1'b0}}, $signed(r_op1) < $signed(r_op2)};
            FN_SLTU:   w_fast_res = {{(XLEN-1){1'b0}}, r_op1 < r_op2};
            FN_MUL:    w_fast_res = (FAST_MUL != 0) ? w_mprod[XLEN-1:0] : '0;
            FN_MULH, FN_MULHSU, FN_MULHU:
                       w_fast_res = (FAST_MUL != 0) ? w_mprod[2*XLEN-1:XLEN] : '0;
            FN_DIV, FN_DIVU:
                       w_fast_res = w_div_zero ? '1 : (w_div_ovf ? r_op1 : '0);
            FN_REM, FN_REMU:
                       w_fast_res = w_div_zero ? r_op1 : '0;
            default:   w_fast_res = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (req_valid_in) w_state_nxt = ST_CALC;
            ST_CALC: if (!r_iter || w_iter_done) w_state_nxt = ST_DONE;
            ST_DONE: if (resp_ready_in) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_res   <= '0;
            r_iter  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) r_iter <= w_start;
            if ((r_state == ST_CALC) && (w_state_nxt == ST_DONE))
                r_res <= r_iter ? w_iter_res : w_fast_res;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_func <= func_in;
            r_op1  <= opnum1_in;
            r_op2  <= opnum2_in;
        end
    end

    assign req_ready_out  = (r_state == ST_IDLE);
    assign resp_valid_out = (r_state == ST_DONE);
    assign busy_out       = (r_state != ST_IDLE);
    assign res_out        = r_res;

endmodule

// File: tb/tb_core_alu_md.sv
// Directed scoreboard bench for core_alu_md (XLEN=32, iterative multiplier).
module tb_core_alu_md;
    import core_alu_md_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid_in;
    logic            req_ready_out;
    logic [4:0]      func_in;
    logic [XLEN-1:0] opnum1_in, opnum2_in;
    logic            resp_valid_out;
    logic            resp_ready_in;
    logic [XLEN-1:0] res_out;
    logic            busy_out;

    int checks = 0;
    int errors = 0;
    logic [XLEN-1:0] sb[$];

    core_alu_md #(.XLEN(XLEN), .FAST_MUL(0)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_in   (req_valid_in),
        .req_ready_out  (req_ready_out),
        .func_in        (func_in),
        .opnum1_in      (opnum1_in),
        .opnum2_in      (opnum2_in),
        .resp_valid_out (resp_valid_out),
        .resp_ready_in  (resp_ready_in),
        .res_out        (res_out),
        .busy_out       (busy_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a request and let it be accepted; leaves time at #1 after the accept edge.
    task automatic issue(input logic [4:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] exp, input bit push, input string tag);
        func_in      = f;
        opnum1_in    = a;
        opnum2_in    = b;
        req_valid_in = 1'b1;
        chk(64'(req_ready_out), 64'd1, {tag, "_ready"});
        if (push) sb.push_back(exp);
        @(posedge clk); #1;
        req_valid_in = 1'b0;
    endtask

    // Wait for the response (bounded), check latency in cycles counted from
    // the accept cycle, then compare against the scoreboard head.
    task automatic collect(input int exp_lat, input string tag);
        logic [XLEN-1:0] exp;
        int n;
        n = 1;
        while (!resp_valid_out && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk(64'(resp_valid_out), 64'd1, {tag, "_valid"});
        chk(64'(n), 64'(exp_lat), {tag, "_latency"});
        if (sb.size() == 0) begin
            chk(64'(res_out), 64'hDEAD_0000_DEAD_0000, {tag, "_sb_empty"});
        end else begin
            exp = sb.pop_front();
            chk(64'(res_out), 64'(exp), {tag, "_res"});
        end
        if (resp_ready_in) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic op(input logic [4:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic [XLEN-1:0] exp, input int lat, input string tag);
        issue(f, a, b, exp, 1'b1, tag);
        collect(lat, tag);
    endtask

    initial begin
        logic [XLEN-1:0] held;
        bit seen;

        // Reset with a simultaneous request: reset must win.
        rst           = 1'b1;
        req_valid_in  = 1'b1;
        func_in       = FN_ADD;
        opnum1_in     = 32'd1;
        opnum2_in     = 32'd2;
        resp_ready_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk(64'(busy_out), 64'd0, "rst_busy");
        chk(64'(resp_valid_out), 64'd0, "rst_resp_valid");
        chk(64'(res_out), 64'd0, "rst_res");
        req_valid_in = 1'b0;
        rst          = 1'b0;
        @(posedge clk); #1;
        chk(64'(req_ready_out), 64'd1, "post_rst_ready");
        chk(64'(busy_out), 64'd0, "post_rst_busy");

        // Basic ops: CALC for one cycle, response in the accept cycle + 2.
        op(FN_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 2, "add_ovf");
        op(FN_SRA,  32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 2, "sra_mask");
        op(FN_SUB,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 2, "sub");
        op(FN_XOR,  32'hF0F0_1234, 32'h0FF0_FFFF, 32'hFF00_EDCB, 2, "xor");
        op(FN_OR,   32'hF000_0001, 32'h0000_0F10, 32'hF000_0F11, 2, "or");
        op(FN_AND,  32'hF0F0_FFFF, 32'h3C3C_00F0, 32'h3030_00F0, 2, "and");
        op(FN_SLL,  32'h0000_0003, 32'h0000_0024, 32'h0000_0030, 2, "sll_mask");
        op(FN_SRL,  32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 2, "srl");
        op(FN_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 2, "slt");
        op(FN_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 2, "sltu");
        op(5'd31,   32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000, 2, "undef");

        // Iterative multiply: XLEN CALC cycles.
        op(FN_MUL,    32'd6,         32'd7,         32'd42,        XLEN + 1, "mul");
        op(FN_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, XLEN + 1, "mulh");
        op(FN_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, XLEN + 1, "mulhu");
        op(FN_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, XLEN + 1, "mulhsu");

        // Divide: normal cases iterate, zero divisor and overflow are one cycle.
        op(FN_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, XLEN + 1, "div_neg");
        op(FN_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, XLEN + 1, "rem_neg");
        op(FN_DIVU, 32'd100,       32'd7,         32'd14,        XLEN + 1, "divu");
        op(FN_REMU, 32'd100,       32'd7,         32'd2,         XLEN + 1, "remu");
        op(FN_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF, 2,        "divu_zero");
        op(FN_REMU, 32'd5,         32'd0,         32'd5,         2,        "remu_zero");
        op(FN_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2,        "div_ovf");
        op(FN_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 2,        "rem_ovf");

        // Backpressure: hold the response 10 cycles, a second request is ignored.
        resp_ready_in = 1'b0;
        issue(FN_ADD, 32'd10, 32'd20, 32'd30, 1'b1, "bp");
        collect(2, "bp");
        held = res_out;
        func_in      = FN_SUB;
        opnum1_in    = 32'd99;
        opnum2_in    = 32'd1;
        req_valid_in = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk(64'(res_out), 64'd30, "bp_res_stable");
        chk(64'(res_out), 64'(held), "bp_res_held");
        chk(64'(resp_valid_out), 64'd1, "bp_valid_held");
        chk(64'(req_ready_out), 64'd0, "bp_ready_low");
        resp_ready_in = 1'b1;
        @(posedge clk); #1;
        req_valid_in = 1'b0;
        chk(64'(busy_out), 64'd0, "bp_idle_after_hs");
        @(posedge clk); #1;
        chk(64'(busy_out), 64'd0, "bp_second_ignored");

        // Reset during CALC cycle 15 of a divide aborts it silently.
        issue(FN_DIVU, 32'd1000, 32'd3, 32'd0, 1'b0, "abort");
        repeat (14) begin
            @(posedge clk); #1;
        end
        chk(64'(busy_out), 64'd1, "abort_busy_before");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk(64'(busy_out), 64'd0, "abort_idle");
        chk(64'(resp_valid_out), 64'd0, "abort_no_valid");
        chk(64'(res_out), 64'd0, "abort_res_cleared");
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (resp_valid_out) seen = 1'b1;
        end
        chk(64'(seen), 64'd0, "abort_no_response");
        op(FN_ADD, 32'd3, 32'd4, 32'd7, 2, "add_after_abort");

        chk(64'(sb.size()), 64'd0, "sb_drained");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
